// File: rtl/id_stage_pipe.sv
// Decode stage: IF/ID decode, register-file addressing with write-back bypass,
// branch resolution, hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc2,
  input  logic              flag_z,
  input  logic              flag_v,
  input  logic              flag_n,
  output logic [REG_AW-1:0] rf_src1,
  output logic [REG_AW-1:0] rf_src2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic              stall,
  output logic              flush_if,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [DATA_W-1:0] ex_pc2,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_halt,
  output logic              halted
);

  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_f118;
  logic [REG_AW-1:0] w_f74;
  logic [REG_AW-1:0] w_f30;
  logic [DATA_W-1:0] w_off_ls;
  logic [DATA_W-1:0] w_off_b;
  logic              w_is_shift;
  logic              w_is_branch;

  assign w_op        = if_instr[15:12];
  assign w_f118      = REG_AW'(if_instr[11:8]);
  assign w_f74       = REG_AW'(if_instr[7:4]);
  assign w_f30       = REG_AW'(if_instr[3:0]);
  assign w_off_ls    = DATA_W'($signed({if_instr[3:0], 1'b0}));
  assign w_off_b     = DATA_W'($signed({if_instr[8:0], 1'b0}));
  assign w_is_shift  = (w_op == OP_SLL) || (w_op == OP_SRA) || (w_op == OP_ROR);
  assign w_is_branch = (w_op == OP_B) || (w_op == OP_BR);

  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_imm;
  logic              w_reg_write;
  logic              w_alu_src;
  logic              w_src2_read;

  // Field decode; opcodes 0000-0111 fall through to the R-format default.
  always_comb begin
    w_rs        = '0;
    w_rt        = '0;
    w_rd        = '0;
    w_imm       = '0;
    w_reg_write = 1'b0;
    w_alu_src   = 1'b0;
    w_src2_read = 1'b0;
    case (w_op)
      OP_LW: begin
        w_rs        = w_f74;
        w_rd        = w_f118;
        w_imm       = w_off_ls;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_SW: begin
        w_rs        = w_f74;
        w_rt        = w_f118;
        w_imm       = w_off_ls;
        w_alu_src   = 1'b1;
        w_src2_read = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        w_rs        = w_f118;
        w_rd        = w_f118;
        w_imm       = DATA_W'(if_instr[7:0]);
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_BR: begin
        w_rs = w_f74;
      end
      OP_PCS: begin
        w_rd        = w_f118;
        w_reg_write = 1'b1;
      end
      OP_B, OP_HLT: begin
        w_rs = '0;
      end
      default: begin
        w_rd        = w_f118;
        w_rs        = w_f74;
        w_rt        = w_f30;
        w_reg_write = 1'b1;
        if (w_is_shift) begin
          w_imm     = DATA_W'(if_instr[3:0]);
          w_alu_src = 1'b1;
        end else begin
          w_src2_read = 1'b1;
        end
      end
    endcase
  end

  assign rf_src1 = w_rs;
  assign rf_src2 = (w_op == OP_SW) ? w_f118 : w_f30;

  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;

  // Write-back bypass; register 0 is never forwarded.
  assign w_opa = (wb_we && (wb_addr == rf_src1) && (rf_src1 != '0)) ? wb_data : rf_data1;
  assign w_opb = (wb_we && (wb_addr == rf_src2) && (rf_src2 != '0)) ? wb_data : rf_data2;

  logic w_cond;

  always_comb begin
    w_cond = 1'b0;
    case (if_instr[11:9])
      3'b000:  w_cond = ~flag_z;
      3'b001:  w_cond = flag_z;
      3'b010:  w_cond = ~flag_z & ~flag_n;
      3'b011:  w_cond = flag_n;
      3'b100:  w_cond = flag_z | (~flag_z & ~flag_n);
      3'b101:  w_cond = flag_n | flag_z;
      3'b110:  w_cond = flag_v;
      default: w_cond = 1'b1;
    endcase
  end

  logic              r_valid;
  logic [3:0]        r_opcode;
  logic [DATA_W-1:0] r_pc2;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              r_alu_src;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic              r_reg_write;
  logic              r_halt;
  logic              r_halted;

  logic w_hz_load;
  logic w_hz_flag;
  logic w_hz_br;
  logic w_load;

  assign w_hz_load = r_mem_read && (r_rd != '0) &&
                     ((r_rd == w_rs) || (w_src2_read && (r_rd == rf_src2)));
  // Flags are still being produced by a flag-setting op currently in EX.
  assign w_hz_flag = w_is_branch && (if_instr[11:9] != 3'b111) && r_valid &&
                     (r_opcode inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6});
  assign w_hz_br   = (w_op == OP_BR) && (w_rs != '0) &&
                     ((r_reg_write && (r_rd == w_rs)) || (mem_reg_write && (mem_rd == w_rs)));

  assign stall         = r_halted || (if_valid && (w_hz_load || w_hz_flag || w_hz_br));
  assign w_load        = if_valid && !stall;
  assign branch_taken  = w_load && w_is_branch && w_cond;
  assign flush_if      = branch_taken;
  assign branch_target = (w_op == OP_BR) ? w_opa : (if_pc2 + w_off_b);

  // ID/EX register: reset and bubbles both clear every field.
  always_ff @(posedge clk) begin
    if (!rst_n || !w_load) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_pc2        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_alu_src    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      r_valid      <= 1'b1;
      r_opcode     <= w_op;
      r_pc2        <= if_pc2;
      r_a          <= w_opa;
      r_b          <= w_opb;
      r_imm        <= w_imm;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_rd         <= w_rd;
      r_alu_src    <= w_alu_src;
      r_mem_read   <= (w_op == OP_LW);
      r_mem_write  <= (w_op == OP_SW);
      r_mem_to_reg <= (w_op == OP_LW);
      r_reg_write  <= w_reg_write;
      r_halt       <= (w_op == OP_HLT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (w_load && (w_op == OP_HLT)) begin
      r_halted <= 1'b1;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_opcode     = r_opcode;
  assign ex_pc2        = r_pc2;
  assign ex_a          = r_a;
  assign ex_b          = r_b;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_alu_src    = r_alu_src;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_reg_write  = r_reg_write;
  assign ex_halt       = r_halt;
  assign halted        = r_halted;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios followed by randomized traffic
// checked against a table-driven reference of the decode/hazard rules.
module tb_id_stage_pipe;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, if_valid, flag_z, flag_v, flag_n;
  logic [15:0]       if_instr;
  logic [DATA_W-1:0] if_pc2, rf_data1, rf_data2, wb_data;
  logic [REG_AW-1:0] rf_src1, rf_src2, wb_addr, mem_rd;
  logic              wb_we, mem_reg_write;
  logic              stall, flush_if, branch_taken;
  logic [DATA_W-1:0] branch_target;
  logic              ex_valid, ex_alu_src, ex_mem_read, ex_mem_write;
  logic              ex_mem_to_reg, ex_reg_write, ex_halt, halted;
  logic [3:0]        ex_opcode;
  logic [DATA_W-1:0] ex_pc2, ex_a, ex_b, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;

  id_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc2(if_pc2), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .stall(stall), .flush_if(flush_if), .branch_taken(branch_taken),
    .branch_target(branch_target), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_pc2(ex_pc2), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_halt(ex_halt), .halted(halted)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] pc2, a, b, imm;
    logic [3:0]  rs, rt, rd;
    logic        alu_src, mr, mw, m2r, rw, halt;
  } ex_t;

  ex_t  m_ex;
  logic m_halted;
  int   checks = 0;
  int   failures = 0;
  logic        obs_stall, obs_taken;
  logic [15:0] obs_target;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-format table.
  function automatic ex_t ref_decode(input logic [15:0] ins);
    ex_t d;
    int op, hi, mid, lo;
    op  = int'(ins[15:12]);
    hi  = int'(ins[11:8]);
    mid = int'(ins[7:4]);
    lo  = int'(ins[3:0]);
    d = '{default: 0};
    d.valid   = 1'b1;
    d.op      = ins[15:12];
    d.halt    = (op == 15);
    d.mr      = (op == 8);
    d.mw      = (op == 9);
    d.m2r     = (op == 8);
    d.rw      = (op <= 8) || (op == 10) || (op == 11) || (op == 14);
    d.alu_src = (op >= 4 && op <= 6) || (op >= 8 && op <= 11);
    if (op <= 7) begin
      d.rd = 4'(hi); d.rs = 4'(mid); d.rt = 4'(lo);
    end else if (op == 8) begin
      d.rd = 4'(hi); d.rs = 4'(mid);
    end else if (op == 9) begin
      d.rt = 4'(hi); d.rs = 4'(mid);
    end else if (op == 10 || op == 11) begin
      d.rd = 4'(hi); d.rs = 4'(hi);
    end else if (op == 13) begin
      d.rs = 4'(mid);
    end else if (op == 14) begin
      d.rd = 4'(hi);
    end
    if (op == 8 || op == 9)
      d.imm = 16'(((lo >= 8) ? lo - 16 : lo) * 2);
    else if (op == 10 || op == 11)
      d.imm = 16'(ins[7:0]);
    else if (op >= 4 && op <= 6)
      d.imm = 16'(lo);
    return d;
  endfunction

  function automatic bit ref_cond(input int ccc, input bit z, input bit v, input bit n);
    case (ccc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // One clock: check combinational outputs, advance the model, check ID/EX.
  task automatic tick();
    ex_t d, nxt;
    int op, off;
    logic [3:0] s2;
    bit s2rd, hz, stall_e, taken_e, load_e;
    logic [15:0] a, b, tgt;
    #2;
    d    = ref_decode(if_instr);
    op   = int'(if_instr[15:12]);
    s2   = (op == 9) ? if_instr[11:8] : if_instr[3:0];
    s2rd = (op <= 7 && !(op >= 4 && op <= 6)) || (op == 9);
    a    = (wb_we && wb_addr == d.rs && d.rs != 4'd0) ? wb_data : rf_data1;
    b    = (wb_we && wb_addr == s2 && s2 != 4'd0) ? wb_data : rf_data2;
    hz   = 1'b0;
    if (m_ex.mr && m_ex.rd != 4'd0 && (m_ex.rd == d.rs || (s2rd && m_ex.rd == s2))) hz = 1'b1;
    if ((op == 12 || op == 13) && if_instr[11:9] != 3'b111 && m_ex.valid &&
        (m_ex.op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6})) hz = 1'b1;
    if (op == 13 && d.rs != 4'd0 &&
        ((m_ex.rw && m_ex.rd == d.rs) || (mem_reg_write && mem_rd == d.rs))) hz = 1'b1;
    stall_e = m_halted || (if_valid && hz);
    load_e  = if_valid && !stall_e;
    taken_e = load_e && (op == 12 || op == 13) &&
              ref_cond(int'(if_instr[11:9]), flag_z, flag_v, flag_n);
    off = int'(if_instr[8:0]);
    if (off >= 256) off = off - 512;
    tgt = (op == 13) ? a : 16'(int'(if_pc2) + off * 2);
    obs_stall  = stall;
    obs_taken  = branch_taken;
    obs_target = branch_target;
    check_eq("rf_src1", 32'(rf_src1), 32'(d.rs));
    check_eq("rf_src2", 32'(rf_src2), 32'(s2));
    check_eq("stall", 32'(stall), 32'(stall_e));
    check_eq("branch_taken", 32'(branch_taken), 32'(taken_e));
    check_eq("flush_if", 32'(flush_if), 32'(taken_e));
    if (taken_e) check_eq("branch_target", 32'(branch_target), 32'(tgt));
    d.a = a; d.b = b; d.pc2 = if_pc2;
    if (!rst_n || !load_e) nxt = '{default: 0};
    else nxt = d;
    if (!rst_n) m_halted = 1'b0;
    else if (load_e && op == 15) m_halted = 1'b1;
    @(posedge clk);
    m_ex = nxt;
    #1;
    check_eq("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
    check_eq("ex_opcode", 32'(ex_opcode), 32'(m_ex.op));
    check_eq("ex_pc2", 32'(ex_pc2), 32'(m_ex.pc2));
    check_eq("ex_a", 32'(ex_a), 32'(m_ex.a));
    check_eq("ex_b", 32'(ex_b), 32'(m_ex.b));
    check_eq("ex_imm", 32'(ex_imm), 32'(m_ex.imm));
    check_eq("ex_rs", 32'(ex_rs), 32'(m_ex.rs));
    check_eq("ex_rt", 32'(ex_rt), 32'(m_ex.rt));
    check_eq("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
    check_eq("ex_alu_src", 32'(ex_alu_src), 32'(m_ex.alu_src));
    check_eq("ex_mem_read", 32'(ex_mem_read), 32'(m_ex.mr));
    check_eq("ex_mem_write", 32'(ex_mem_write), 32'(m_ex.mw));
    check_eq("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m_ex.m2r));
    check_eq("ex_reg_write", 32'(ex_reg_write), 32'(m_ex.rw));
    check_eq("ex_halt", 32'(ex_halt), 32'(m_ex.halt));
    check_eq("halted", 32'(halted), 32'(m_halted));
  endtask

  task automatic set_idle();
    rst_n = 1'b1; if_valid = 1'b0; if_instr = 16'h0000; if_pc2 = 16'h0000;
    flag_z = 1'b0; flag_v = 1'b0; flag_n = 1'b0;
    rf_data1 = 16'h0000; rf_data2 = 16'h0000;
    wb_we = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
    mem_rd = 4'd0; mem_reg_write = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    int op;
    logic [11:0] low;
    op = $urandom_range(0, 15);
    if (op == 15 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 14);
    low = 12'($urandom);
    if (op == 13) low = low & 12'hE7F;
    else if (op != 12) low = low & 12'h777;
    return {4'(op), low};
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    m_ex = '{default: 0};
    m_halted = 1'b0;
    obs_stall = 1'b0; obs_taken = 1'b0; obs_target = 16'h0000;
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("reset_ex_a", 32'(ex_a), 32'd0);
    check_eq("reset_halted", 32'(halted), 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // Load-use: LW R1,R2,2 then ADD R3,R1,R4
    if_valid = 1'b1; if_instr = 16'h8121; tick();
    if_instr = 16'h0314; tick();
    check_eq("lu_stall", 32'(obs_stall), 32'd1);
    check_eq("lu_bubble", 32'(ex_valid), 32'd0);
    tick();
    check_eq("lu_release", 32'(obs_stall), 32'd0);
    check_eq("lu_ex_rs", 32'(ex_rs), 32'd1);

    // B ccc=001 offset 4 from 0x0100
    if_valid = 1'b0; tick();
    if_valid = 1'b1; if_instr = 16'hC204; if_pc2 = 16'h0100; flag_z = 1'b1; tick();
    check_eq("b_taken", 32'(obs_taken), 32'd1);
    check_eq("b_target", 32'(obs_target), 32'h0108);
    flag_z = 1'b0; tick();
    check_eq("b_not_taken", 32'(obs_taken), 32'd0);

    // SUB then B ccc=000: one flag stall, then resolve
    if_instr = 16'h1123; tick();
    if_instr = 16'hC010; tick();
    check_eq("flag_stall", 32'(obs_stall), 32'd1);
    tick();
    check_eq("flag_release", 32'(obs_stall), 32'd0);
    check_eq("flag_taken", 32'(obs_taken), 32'd1);
    check_eq("flag_target", 32'(obs_target), 32'h0120);

    // Write-back bypass on operand 1
    if_instr = 16'h0350; wb_we = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF; rf_data1 = 16'h1111; tick();
    check_eq("bypass_hit", 32'(ex_a), 32'hBEEF);
    if_instr = 16'h0300; tick();
    check_eq("bypass_r0", 32'(ex_a), 32'h1111);
    wb_we = 1'b0;

    // BR R7 blocked by MEM writer of R7
    if_instr = 16'hDE70; mem_reg_write = 1'b1; mem_rd = 4'd7; rf_data1 = 16'h2468; tick();
    check_eq("br_stall0", 32'(obs_stall), 32'd1);
    tick();
    check_eq("br_stall1", 32'(obs_stall), 32'd1);
    mem_reg_write = 1'b0; tick();
    check_eq("br_taken", 32'(obs_taken), 32'd1);
    check_eq("br_target", 32'(obs_target), 32'h2468);

    // HLT then stuck until reset
    if_instr = 16'hF000; tick();
    check_eq("hlt_ex_halt", 32'(ex_halt), 32'd1);
    check_eq("hlt_halted", 32'(halted), 32'd1);
    if_instr = 16'h0123;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("halt_stall", 32'(obs_stall), 32'd1);
      check_eq("halt_bubble", 32'(ex_valid), 32'd0);
    end
    rst_n = 1'b0; tick();
    check_eq("halt_reset", 32'(halted), 32'd0);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n    = ($urandom_range(0, 99) != 0) && !(m_halted && $urandom_range(0, 5) == 0);
      if_valid = ($urandom_range(0, 9) != 0);
      if (!(obs_stall && $urandom_range(0, 3) != 0)) if_instr = rand_instr();
      if_pc2        = 16'($urandom) & 16'hFFFE;
      flag_z        = 1'($urandom);
      flag_v        = 1'($urandom);
      flag_n        = 1'($urandom);
      rf_data1      = 16'($urandom);
      rf_data2      = 16'($urandom);
      wb_we         = 1'($urandom);
      wb_addr       = 4'($urandom_range(0, 7));
      wb_data       = 16'($urandom);
      mem_rd        = 4'($urandom_range(0, 7));
      mem_reg_write = 1'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
